// File: rtl/pattern_history_table.sv
// rtl/pattern_history_table.sv - gshare-style pattern history table of saturating counters
// Flop-based table, self-initialised after reset, with one lookup and one update per cycle.
module pattern_history_table #(
  parameter int R = 4,
  parameter int M = 2,
  parameter int N = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           rd_en,
  input  logic [R+M-1:0] rd_addr,
  output logic [N-1:0]   rd_state,
  output logic           rd_valid,
  output logic           predict,
  input  logic           upd_en,
  input  logic [R+M-1:0] upd_addr,
  input  logic           upd_taken,
  output logic           busy,
  output logic [15:0]    upd_count,
  output logic [15:0]    miss_count
);

  localparam int AW    = R + M;
  localparam int DEPTH = 1 << AW;
  localparam logic [N-1:0]  INIT_VAL = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]  MAX_VAL  = '1;
  localparam logic [AW-1:0] LAST_IDX = '1;
  localparam logic [15:0]   CNT_MAX  = 16'hFFFF;

  typedef enum logic {INIT, READY} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [N-1:0]  table_q [DEPTH];

  logic          rd_fire;
  logic          upd_fire;
  logic [N-1:0]  upd_old;
  logic [N-1:0]  upd_new;
  logic          mispredict;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // idx naturally wraps back to 0 on the last INIT write, ready for the next reset
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      INIT: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) state_d = READY;
      end
      READY: ;
      default: begin
        state_d = INIT;
        idx_d   = '0;
      end
    endcase
  end

  assign busy     = (state_q == INIT);
  assign rd_fire  = rd_en && !busy;
  assign upd_fire = upd_en && !busy;

  always_comb begin
    upd_old    = table_q[upd_addr];
    upd_new    = upd_old;
    mispredict = (upd_old[N-1] != upd_taken);
    if (upd_taken && (upd_old != MAX_VAL))
      upd_new = upd_old + 1'b1;
    else if (!upd_taken && (upd_old != '0))
      upd_new = upd_old - 1'b1;
  end

  // Table contents are deliberately not reset; INIT rewrites every entry instead.
  always_ff @(posedge clk) begin
    if (busy)
      table_q[idx_q] <= INIT_VAL;
    else if (upd_fire)
      table_q[upd_addr] <= upd_new;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_state <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_fire;
      if (rd_fire) begin
        if (upd_fire && (upd_addr == rd_addr))
          rd_state <= upd_new;
        else
          rd_state <= table_q[rd_addr];
      end
    end
  end

  assign predict = rd_state[N-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      upd_count  <= '0;
      miss_count <= '0;
    end else if (upd_fire) begin
      if (upd_count != CNT_MAX)
        upd_count <= upd_count + 1'b1;
      if (mispredict && (miss_count != CNT_MAX))
        miss_count <= miss_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pattern_history_table.sv
// tb/tb_pattern_history_table.sv - directed bench for pattern_history_table
// Vector table for READY-state behaviour plus hand sequences for init, reset and saturation.
module tb_pattern_history_table;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_en;
  logic [5:0]  rd_addr;
  logic [1:0]  rd_state;
  logic        rd_valid;
  logic        predict;
  logic        upd_en;
  logic [5:0]  upd_addr;
  logic        upd_taken;
  logic        busy;
  logic [15:0] upd_count;
  logic [15:0] miss_count;

  int total = 0;
  int passed = 0;

  pattern_history_table #(.R(4), .M(2), .N(2)) dut (
    .clk(clk), .reset(reset),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_state(rd_state), .rd_valid(rd_valid),
    .predict(predict),
    .upd_en(upd_en), .upd_addr(upd_addr), .upd_taken(upd_taken),
    .busy(busy), .upd_count(upd_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd_en;
    logic [5:0]  rd_addr;
    logic        upd_en;
    logic [5:0]  upd_addr;
    logic        taken;
    logic        exp_valid;
    logic [1:0]  exp_state;
    logic [15:0] exp_upd;
    logic [15:0] exp_miss;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init(input string name, input int exp_cycles);
    int  cnt;
    logic bad_valid;
    cnt = 0;
    bad_valid = 1'b0;
    while (busy && cnt < 200) begin
      step();
      cnt++;
      if (cnt == 3) upd_en = 1'b0;
      if (rd_valid) bad_valid = 1'b1;
    end
    chk({name, "_init_cycles"}, cnt, exp_cycles);
    chk({name, "_valid_in_init"}, bad_valid, 1'b0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 6'h15, 1'b1, 6'h15, 1'b1, 1'b1, 2'b10, 16'd1,  16'd1};
    vecs[1]  = '{1'b1, 6'h15, 1'b1, 6'h15, 1'b1, 1'b1, 2'b11, 16'd2,  16'd1};
    vecs[2]  = '{1'b1, 6'h15, 1'b1, 6'h15, 1'b1, 1'b1, 2'b11, 16'd3,  16'd1};
    vecs[3]  = '{1'b1, 6'h15, 1'b1, 6'h15, 1'b1, 1'b1, 2'b11, 16'd4,  16'd1};
    vecs[4]  = '{1'b1, 6'h00, 1'b1, 6'h00, 1'b0, 1'b1, 2'b00, 16'd5,  16'd1};
    vecs[5]  = '{1'b1, 6'h00, 1'b1, 6'h00, 1'b0, 1'b1, 2'b00, 16'd6,  16'd1};
    vecs[6]  = '{1'b1, 6'h00, 1'b1, 6'h00, 1'b0, 1'b1, 2'b00, 16'd7,  16'd1};
    vecs[7]  = '{1'b0, 6'h00, 1'b1, 6'h03, 1'b1, 1'b0, 2'b00, 16'd8,  16'd2};
    vecs[8]  = '{1'b1, 6'h03, 1'b1, 6'h03, 1'b0, 1'b1, 2'b01, 16'd9,  16'd3};
    vecs[9]  = '{1'b1, 6'h15, 1'b1, 6'h20, 1'b0, 1'b1, 2'b11, 16'd10, 16'd3};
    vecs[10] = '{1'b1, 6'h20, 1'b0, 6'h00, 1'b0, 1'b1, 2'b00, 16'd10, 16'd3};
    vecs[11] = '{1'b1, 6'h3F, 1'b0, 6'h00, 1'b0, 1'b1, 2'b01, 16'd10, 16'd3};
    vecs[12] = '{1'b0, 6'h00, 1'b1, 6'h20, 1'b1, 1'b0, 2'b01, 16'd11, 16'd4};
    vecs[13] = '{1'b1, 6'h20, 1'b0, 6'h00, 1'b0, 1'b1, 2'b01, 16'd11, 16'd4};

    reset = 1'b1; rd_en = 1'b0; rd_addr = '0;
    upd_en = 1'b0; upd_addr = '0; upd_taken = 1'b0;
    #2 reset = 1'b0;
    step(); step();
    chk("rst_busy", busy, 1'b1);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_state", rd_state, 2'b00);
    chk("rst_upd_count", upd_count, 16'd0);
    chk("rst_miss_count", miss_count, 16'd0);

    // release between edges with a read held high through INIT
    @(negedge clk);
    reset = 1'b1; rd_en = 1'b1; rd_addr = 6'h15;
    #4;
    wait_init("boot", 64);
    step();
    chk("first_read_valid", rd_valid, 1'b1);
    chk("first_read_state", rd_state, 2'b01);
    chk("first_read_predict", predict, 1'b0);
    chk("init_no_count", upd_count, 16'd0);

    foreach (vecs[i]) begin
      rd_en = vecs[i].rd_en; rd_addr = vecs[i].rd_addr;
      upd_en = vecs[i].upd_en; upd_addr = vecs[i].upd_addr; upd_taken = vecs[i].taken;
      step();
      chk($sformatf("vec%0d_valid", i), rd_valid, vecs[i].exp_valid);
      chk($sformatf("vec%0d_state", i), rd_state, vecs[i].exp_state);
      chk($sformatf("vec%0d_predict", i), predict, vecs[i].exp_state[1]);
      chk($sformatf("vec%0d_upd_count", i), upd_count, vecs[i].exp_upd);
      chk($sformatf("vec%0d_miss_count", i), miss_count, vecs[i].exp_miss);
    end

    // mid-run reset pulse with an update pending; entry 0x15 holds 11
    rd_en = 1'b0; upd_en = 1'b1; upd_addr = 6'h15; upd_taken = 1'b1;
    reset = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b1);
    chk("midrst_upd_count", upd_count, 16'd0);
    chk("midrst_miss_count", miss_count, 16'd0);
    chk("midrst_rd_valid", rd_valid, 1'b0);
    #4 reset = 1'b1;
    #1;
    wait_init("rerun", 64);
    rd_en = 1'b1; rd_addr = 6'h15;
    step();
    chk("midrst_read_state", rd_state, 2'b01);
    chk("midrst_read_valid", rd_valid, 1'b1);
    chk("midrst_counts_clean", {upd_count, miss_count}, 32'd0);

    // alternating outcomes on a fresh 01 entry mispredict on every update
    rd_en = 1'b0; upd_en = 1'b1; upd_addr = 6'h2A;
    for (int i = 0; i < 65540; i++) begin
      upd_taken = (i % 2 == 0);
      step();
      if (i == 65533) begin
        chk("sat_pre_upd", upd_count, 16'hFFFE);
        chk("sat_pre_miss", miss_count, 16'hFFFE);
      end
    end
    upd_en = 1'b0;
    chk("sat_upd_count", upd_count, 16'hFFFF);
    chk("sat_miss_count", miss_count, 16'hFFFF);
    rd_en = 1'b1; rd_addr = 6'h2A;
    step();
    chk("sat_entry", rd_state, 2'b01);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pattern_history_table.md
PATTERN_HISTORY_TABLE -- requirements
Module: pattern_history_table

Interface
REQ-001 The block SHALL have parameter R, default 4, meaning the number of PC bits used in the index.
REQ-002 The block SHALL have parameter M, default 2, meaning the number of global-history bits used in the index.
REQ-003 The block SHALL have parameter N, default 2, meaning the saturating-counter width in bits.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port rd_en, input, 1 bit: prediction lookup request.
REQ-007 Port rd_addr, input, R+M bits: lookup index, formed as {PC[R-1:0], history[M-1:0]}.
REQ-008 Port rd_state, output, N bits: registered counter value for the lookup.
REQ-009 Port rd_valid, output, 1 bit: rd_state is valid this cycle.
REQ-010 Port predict, output, 1 bit: equals rd_state[N-1], i.e. taken = 1.
REQ-011 Port upd_en, input, 1 bit: resolved-branch update request.
REQ-012 Port upd_addr, input, R+M bits: index of the entry to update.
REQ-013 Port upd_taken, input, 1 bit: actual branch outcome.
REQ-014 Port busy, output, 1 bit: table is initialising; requests are ignored.
REQ-015 Port upd_count, output, 16 bits: number of accepted updates.
REQ-016 Port miss_count, output, 16 bits: number of accepted updates that were mispredicted.

Function
REQ-017 Storage SHALL be 2^(R+M) entries of N bits, held in flops.
REQ-018 The FSM SHALL have two states, INIT and READY.
REQ-019 INIT SHALL write INIT_VAL = 2^(N-1)-1 (weakly not-taken; 01 for N=2) to entry idx on each cycle, with idx starting at 0 and incrementing by 1.
REQ-020 When idx = 2^(R+M)-1 is written, the FSM SHALL move to READY on that edge; INIT therefore lasts exactly 2^(R+M) cycles (64 at defaults).
REQ-021 busy SHALL be 1 in INIT and 0 in READY.
REQ-022 In INIT, rd_en and upd_en SHALL be ignored: rd_valid stays 0, and neither the table nor the counters change.
REQ-023 Read, READY only: rd_en sampled high at edge k SHALL give rd_valid = 1 and rd_state = entry[rd_addr] after edge k; when rd_en is low, rd_valid = 0 and rd_state holds its last value.
REQ-024 Update, READY only: upd_en high at edge k SHALL modify entry[upd_addr] at edge k.
REQ-025 The update SHALL add 1 if upd_taken = 1 and the entry is below 2^N-1.
REQ-026 The update SHALL subtract 1 if upd_taken = 0 and the entry is above 0.
REQ-027 Otherwise the update SHALL leave the entry unchanged (saturation, no wrap).
REQ-028 Misprediction SHALL be defined as the old entry MSB differing from upd_taken.
REQ-029 On each accepted update, upd_count SHALL increment, and miss_count SHALL increment on a misprediction; both saturate at 16'hFFFF and never wrap.
REQ-030 If rd_en and upd_en are both high in the same cycle with rd_addr = upd_addr, rd_state SHALL return the post-update value (write-first forwarding).
REQ-031 If rd_en and upd_en are both high with different addresses, both SHALL complete independently in that cycle.
REQ-032 Throughput SHALL be one read and one update per cycle, with no back-pressure in READY.

Reset
REQ-033 While reset = 0, and asynchronously on its assertion, the block SHALL force: FSM to INIT, idx = 0, rd_state = 0, rd_valid = 0, busy = 1, upd_count = 0, miss_count = 0.
REQ-034 Table contents SHALL NOT be reset directly; INIT rewrites every entry after reset is released.
REQ-035 A reset asserted during INIT or READY SHALL abort all activity and restart INIT from idx 0; no partial update SHALL be counted.

Verification
REQ-036 Init: release reset, hold rd_en = 1 -> busy = 1 for exactly 64 cycles and rd_valid = 0 throughout; on the first READY read of any address, rd_state = 01 and predict = 0.
REQ-037 Saturation up: 4 updates to addr 6'h15 with taken = 1 -> entry 01->10->11->11->11; upd_count = 4; miss_count = 1 (first update only).
REQ-038 Saturation down: 3 updates to addr 0 with taken = 0 -> entry 01->00->00->00; miss_count = 0.
REQ-039 Forwarding: entry 0x3 holds 10; read 0x3 and update 0x3 with taken = 0 in the same cycle -> rd_state = 01 next cycle.
REQ-040 Mid-run reset: pulse reset low for half a cycle during READY with upd_en = 1 -> busy = 1 immediately, counters = 0, and a read of the previously updated entry after the new INIT returns 01.
REQ-041 Counter saturation: apply 65,540 mispredicting updates -> upd_count = miss_count = 16'hFFFF, with no wrap.
